// File: rtl/qea_host_sequencer.sv
// Host command sequencer for QEA: loads gate context, initialises state to |0..0>, times a run, streams state out.
// Optional run watchdog is compiled in when QEA_SEQ_TIMEOUT_EN is defined; otherwise o_timeout is tied 0.
module qea_host_sequencer #(
    parameter int          PE_NUM_WIDTH            = 2,
    parameter int          DATA_WIDTH              = 32,
    parameter int          MAX_QBIT_WIDTH          = 6,
    parameter int          STATE_ADDR_WIDTH        = 16,
    parameter int          GATE_CONTEXT_ADDR_WIDTH = 16,
    parameter int          NUM_FRAC_BIT            = 30,
    parameter int          CYCLE_CNT_WIDTH         = 32,
    parameter int unsigned TIMEOUT_CYCLES          = 2**24
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          i_cmd_valid,
    output logic                                          o_cmd_ready,
    input  logic [1:0]                                    i_cmd_op,
    input  logic [GATE_CONTEXT_ADDR_WIDTH-1:0]            i_cmd_len,
    input  logic [MAX_QBIT_WIDTH-1:0]                     i_qbit_num,
    input  logic                                          i_ctx_valid,
    output logic                                          o_ctx_ready,
    input  logic [2*DATA_WIDTH-1:0]                       i_ctx_data,
    output logic                                          o_ctx_en,
    output logic                                          o_ctx_wea,
    output logic [GATE_CONTEXT_ADDR_WIDTH-1:0]            o_ctx_addr,
    output logic [2*DATA_WIDTH-1:0]                       o_ctx_data,
    output logic                                          o_state_ena,
    output logic                                          o_state_wea,
    output logic [STATE_ADDR_WIDTH-1:0]                   o_state_addra,
    output logic [(2**PE_NUM_WIDTH)*2*DATA_WIDTH-1:0]     o_state_dina,
    input  logic [(2**PE_NUM_WIDTH)*2*DATA_WIDTH-1:0]     i_state_dout,
    output logic                                          o_start,
    input  logic                                          i_complete,
    output logic                                          o_rd_valid,
    input  logic                                          i_rd_ready,
    output logic [(2**PE_NUM_WIDTH)*2*DATA_WIDTH-1:0]     o_rd_data,
    output logic                                          o_busy,
    output logic                                          o_done,
    output logic [CYCLE_CNT_WIDTH-1:0]                    o_cycle_count,
    output logic                                          o_timeout
);
    localparam int PE_NUM  = 2**PE_NUM_WIDTH;
    localparam int AMP_W   = 2*DATA_WIDTH;
    localparam int WORD_W  = PE_NUM*AMP_W;
    localparam int ONE_BIT = (PE_NUM-1)*AMP_W + DATA_WIDTH + NUM_FRAC_BIT;
    localparam logic [STATE_ADDR_WIDTH-1:0]        SA_ONE  = 1;
    localparam logic [GATE_CONTEXT_ADDR_WIDTH-1:0] GC_ONE  = 1;
    localparam logic [CYCLE_CNT_WIDTH-1:0]         CNT_ONE = 1;

    typedef enum logic [1:0] {OP_LOAD, OP_INIT, OP_RUN, OP_READ} op_e;
    typedef enum logic [3:0] {IDLE, LOAD, INIT, START, RUN, RD_REQ, RD_WAIT, RD_HOLD, DONE} state_e;

    state_e                              state_q, state_d;
    logic [GATE_CONTEXT_ADDR_WIDTH-1:0]  len_q, len_d, load_cnt_q, load_cnt_d;
    logic [STATE_ADDR_WIDTH-1:0]         idx_q, idx_d, last_q, last_d;
    logic                                ctx_we_q, ctx_we_d;
    logic [GATE_CONTEXT_ADDR_WIDTH-1:0]  ctx_addr_q, ctx_addr_d;
    logic [AMP_W-1:0]                    ctx_data_q, ctx_data_d;
    logic                                st_ena_q, st_ena_d, st_wea_q, st_wea_d;
    logic [STATE_ADDR_WIDTH-1:0]         st_addr_q, st_addr_d;
    logic [WORD_W-1:0]                   st_dina_q, st_dina_d;
    logic                                rd_valid_q, rd_valid_d;
    logic [WORD_W-1:0]                   rd_data_q, rd_data_d;
    logic [CYCLE_CNT_WIDTH-1:0]          cycle_cnt_q, cycle_cnt_d;
`ifdef QEA_SEQ_TIMEOUT_EN
    localparam logic [CYCLE_CNT_WIDTH-1:0] TIMEOUT_VAL = CYCLE_CNT_WIDTH'(TIMEOUT_CYCLES);
    logic                                timeout_q, timeout_d;
`else
    logic [31:0]                         unused_timeout_cfg;
    assign unused_timeout_cfg = TIMEOUT_CYCLES;
`endif

    // Index of the last state word: 2**(qbit-PE_NUM_WIDTH)-1, at least 0, clamped to the address space.
    function automatic logic [STATE_ADDR_WIDTH-1:0] last_word(input logic [MAX_QBIT_WIDTH-1:0] qbit);
        int                        exp_n;
        logic [STATE_ADDR_WIDTH:0] one_hot;
        exp_n = (int'(qbit) > PE_NUM_WIDTH) ? int'(qbit) - PE_NUM_WIDTH : 0;
        if (exp_n >= STATE_ADDR_WIDTH) return '1;
        one_hot        = '0;
        one_hot[exp_n] = 1'b1;
        return STATE_ADDR_WIDTH'(one_hot - (STATE_ADDR_WIDTH+1)'(1));
    endfunction

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        load_cnt_d  = load_cnt_q;
        idx_d       = idx_q;
        last_d      = last_q;
        ctx_we_d    = 1'b0;
        ctx_addr_d  = ctx_addr_q;
        ctx_data_d  = ctx_data_q;
        st_ena_d    = 1'b0;
        st_wea_d    = 1'b0;
        st_addr_d   = st_addr_q;
        st_dina_d   = st_dina_q;
        rd_valid_d  = rd_valid_q;
        rd_data_d   = rd_data_q;
        cycle_cnt_d = cycle_cnt_q;
`ifdef QEA_SEQ_TIMEOUT_EN
        timeout_d   = timeout_q;
`endif
        case (state_q)
            IDLE: if (i_cmd_valid) begin
                case (op_e'(i_cmd_op))
                    OP_LOAD: begin
                        len_d      = i_cmd_len;
                        load_cnt_d = '0;
                        state_d    = (i_cmd_len == '0) ? DONE : LOAD;
                    end
                    OP_INIT: begin
                        last_d  = last_word(i_qbit_num);
                        idx_d   = '0;
                        state_d = INIT;
                    end
                    OP_RUN: begin
                        cycle_cnt_d = '0;
                        state_d     = START;
                    end
                    default: begin
                        // Issue the first read so the strobe is visible while in RD_REQ.
                        last_d    = last_word(i_qbit_num);
                        idx_d     = '0;
                        st_ena_d  = 1'b1;
                        st_addr_d = '0;
                        state_d   = RD_REQ;
                    end
                endcase
            end
            LOAD: if (i_ctx_valid) begin
                ctx_we_d   = 1'b1;
                ctx_addr_d = load_cnt_q;
                ctx_data_d = i_ctx_data;
                load_cnt_d = load_cnt_q + GC_ONE;
                if (load_cnt_q == len_q - GC_ONE) state_d = DONE;
            end
            INIT: begin
                st_ena_d  = 1'b1;
                st_wea_d  = 1'b1;
                st_addr_d = idx_q;
                st_dina_d = '0;
                if (idx_q == '0) st_dina_d[ONE_BIT] = 1'b1;
                if (idx_q == last_q) state_d = DONE;
                else                 idx_d   = idx_q + SA_ONE;
            end
            START: state_d = RUN;
            RUN: begin
                if (cycle_cnt_q != '1) cycle_cnt_d = cycle_cnt_q + CNT_ONE;
                if (i_complete) state_d = DONE;
`ifdef QEA_SEQ_TIMEOUT_EN
                else if (cycle_cnt_d >= TIMEOUT_VAL) begin
                    timeout_d = 1'b1;
                    state_d   = DONE;
                end
`endif
            end
            RD_REQ: state_d = RD_WAIT;
            RD_WAIT: begin
                rd_data_d  = i_state_dout;
                rd_valid_d = 1'b1;
                state_d    = RD_HOLD;
            end
            RD_HOLD: if (i_rd_ready) begin
                rd_valid_d = 1'b0;
                if (idx_q == last_q) state_d = DONE;
                else begin
                    idx_d     = idx_q + SA_ONE;
                    st_ena_d  = 1'b1;
                    st_addr_d = idx_q + SA_ONE;
                    state_d   = RD_REQ;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            len_q       <= '0;
            load_cnt_q  <= '0;
            idx_q       <= '0;
            last_q      <= '0;
            ctx_we_q    <= 1'b0;
            ctx_addr_q  <= '0;
            ctx_data_q  <= '0;
            st_ena_q    <= 1'b0;
            st_wea_q    <= 1'b0;
            st_addr_q   <= '0;
            st_dina_q   <= '0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
            cycle_cnt_q <= '0;
`ifdef QEA_SEQ_TIMEOUT_EN
            timeout_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            load_cnt_q  <= load_cnt_d;
            idx_q       <= idx_d;
            last_q      <= last_d;
            ctx_we_q    <= ctx_we_d;
            ctx_addr_q  <= ctx_addr_d;
            ctx_data_q  <= ctx_data_d;
            st_ena_q    <= st_ena_d;
            st_wea_q    <= st_wea_d;
            st_addr_q   <= st_addr_d;
            st_dina_q   <= st_dina_d;
            rd_valid_q  <= rd_valid_d;
            rd_data_q   <= rd_data_d;
            cycle_cnt_q <= cycle_cnt_d;
`ifdef QEA_SEQ_TIMEOUT_EN
            timeout_q   <= timeout_d;
`endif
        end
    end

    assign o_cmd_ready   = (state_q == IDLE);
    assign o_busy        = (state_q != IDLE);
    assign o_ctx_ready   = (state_q == LOAD);
    assign o_start       = (state_q == START);
    assign o_done        = (state_q == DONE);
    assign o_ctx_en      = ctx_we_q;
    assign o_ctx_wea     = ctx_we_q;
    assign o_ctx_addr    = ctx_addr_q;
    assign o_ctx_data    = ctx_data_q;
    assign o_state_ena   = st_ena_q;
    assign o_state_wea   = st_wea_q;
    assign o_state_addra = st_addr_q;
    assign o_state_dina  = st_dina_q;
    assign o_rd_valid    = rd_valid_q;
    assign o_rd_data     = rd_data_q;
    assign o_cycle_count = cycle_cnt_q;
`ifdef QEA_SEQ_TIMEOUT_EN
    assign o_timeout     = timeout_q;
`else
    assign o_timeout     = 1'b0;
`endif

endmodule

// File: tb/tb_qea_host_sequencer.sv
// Randomised bench for qea_host_sequencer: context load, state init, run timing, readout, reset abort.
module tb_qea_host_sequencer;
    typedef logic [255:0] w_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         i_cmd_valid, i_ctx_valid, i_complete, i_rd_ready;
    logic [1:0]   i_cmd_op;
    logic [15:0]  i_cmd_len;
    logic [5:0]   i_qbit_num;
    logic [63:0]  i_ctx_data;
    logic [255:0] i_state_dout;
    logic         o_cmd_ready, o_ctx_ready, o_ctx_en, o_ctx_wea, o_state_ena, o_state_wea;
    logic [15:0]  o_ctx_addr, o_state_addra;
    logic [63:0]  o_ctx_data;
    logic [255:0] o_state_dina, o_rd_data;
    logic         o_start, o_rd_valid, o_busy, o_done, o_timeout;
    logic [31:0]  o_cycle_count;

    int checks = 0;
    int errors = 0;
    logic [31:0] salt;

    always #5 clk = ~clk;

    qea_host_sequencer #(.TIMEOUT_CYCLES(1000)) dut (
        .clk(clk), .rst(rst),
        .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_op(i_cmd_op),
        .i_cmd_len(i_cmd_len), .i_qbit_num(i_qbit_num),
        .i_ctx_valid(i_ctx_valid), .o_ctx_ready(o_ctx_ready), .i_ctx_data(i_ctx_data),
        .o_ctx_en(o_ctx_en), .o_ctx_wea(o_ctx_wea), .o_ctx_addr(o_ctx_addr), .o_ctx_data(o_ctx_data),
        .o_state_ena(o_state_ena), .o_state_wea(o_state_wea), .o_state_addra(o_state_addra),
        .o_state_dina(o_state_dina), .i_state_dout(i_state_dout),
        .o_start(o_start), .i_complete(i_complete),
        .o_rd_valid(o_rd_valid), .i_rd_ready(i_rd_ready), .o_rd_data(o_rd_data),
        .o_busy(o_busy), .o_done(o_done), .o_cycle_count(o_cycle_count), .o_timeout(o_timeout)
    );

    // Reference state contents for readout: a per-address, per-lane pattern.
    function automatic w_t pattern(input logic [15:0] a);
        w_t r;
        for (int k = 0; k < 4; k++) r[k*64 +: 64] = {salt ^ {16'(k), a}, salt + {a, 16'(k)}};
        return r;
    endfunction

    function automatic int n_words(input int q);
        return (q <= 2) ? 1 : (1 << (q - 2));
    endfunction

    // State RAM read port: 1-cycle latency, garbage when not reading.
    always @(posedge clk) begin
        if (o_state_ena && !o_state_wea) i_state_dout <= pattern(o_state_addra);
        else                             i_state_dout <= {8{$urandom}};
    end

    logic [15:0]  ctx_addr_log[$];
    logic [63:0]  ctx_data_log[$];
    logic [15:0]  wr_addr_log[$];
    logic [255:0] wr_data_log[$];
    logic [15:0]  rd_addr_log[$];
    logic [255:0] beat_log[$];
    int           done_cnt = 0, start_cnt = 0, stall_err = 0, strobe_err = 0;
    logic         prev_stall = 1'b0;
    logic [255:0] prev_data = '0;

    always @(negedge clk) begin
        if (!rst) begin
            if (o_ctx_en) begin
                ctx_addr_log.push_back(o_ctx_addr);
                ctx_data_log.push_back(o_ctx_data);
            end
            if (o_ctx_en != o_ctx_wea) strobe_err++;
            if (o_state_ena && o_state_wea) begin
                wr_addr_log.push_back(o_state_addra);
                wr_data_log.push_back(o_state_dina);
            end
            if (o_state_ena && !o_state_wea) rd_addr_log.push_back(o_state_addra);
            if (o_rd_valid && i_rd_ready) beat_log.push_back(o_rd_data);
            if (prev_stall && (!o_rd_valid || o_rd_data !== prev_data)) stall_err++;
            prev_stall = o_rd_valid && !i_rd_ready;
            prev_data  = o_rd_data;
            if (o_done)  done_cnt++;
            if (o_start) start_cnt++;
        end
    end

    task automatic check(input string tag, input w_t got, input w_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic send_cmd(input logic [1:0] op, input logic [15:0] len, input logic [5:0] q);
        int n = 0;
        @(negedge clk);
        while (!o_cmd_ready && n < 5000) begin @(negedge clk); n++; end
        check("cmd_ready_wait", w_t'(o_cmd_ready), w_t'(1));
        i_cmd_valid = 1'b1; i_cmd_op = op; i_cmd_len = len; i_qbit_num = q;
        @(posedge clk); #1;
        i_cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (!o_done && n < budget) begin @(negedge clk); n++; end
        check(tag, w_t'(o_done), w_t'(1));
    endtask

    task automatic wait_start();
        int n = 0;
        @(negedge clk);
        while (!o_start && n < 20) begin @(negedge clk); n++; end
        check("start_seen", w_t'(o_start), w_t'(1));
    endtask

    task automatic run_test(input int k, input logic exp_to);
        int d0 = done_cnt, s0 = start_cnt;
        send_cmd(2'd2, 16'd0, 6'd0);
        wait_start();
        check("count_cleared", w_t'(o_cycle_count), w_t'(0));
        repeat (k) @(posedge clk);
        #1 i_complete = 1'b1;
        @(negedge clk);
        wait_done("run_done", 10);
        check("run_count", w_t'(o_cycle_count), w_t'(k));
        i_complete = 1'b0;
        repeat (4) @(negedge clk);
        check("run_count_frozen", w_t'(o_cycle_count), w_t'(k));
        check("run_one_start", w_t'(start_cnt - s0), w_t'(1));
        check("run_one_done", w_t'(done_cnt - d0), w_t'(1));
        check("run_timeout", w_t'(o_timeout), w_t'(exp_to));
    endtask

    initial begin
        int base, rbase, d0, n, nw, got;
        logic [63:0] exp_ctx[$];
        int qtab[3];
        w_t one_vec;
        one_vec = w_t'(64'h40000000_00000000) << 192;
        qtab = '{9, 1, 3};
        i_cmd_valid = 0; i_cmd_op = 0; i_cmd_len = 0; i_qbit_num = 0;
        i_ctx_valid = 0; i_ctx_data = 0; i_complete = 0; i_rd_ready = 0;
        salt = $urandom;
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", w_t'(o_cmd_ready), w_t'(1));
        check("rst_busy", w_t'(o_busy), w_t'(0));
        check("rst_strobes", w_t'({o_ctx_en, o_state_ena, o_start, o_done, o_rd_valid, o_ctx_ready}), w_t'(0));
        check("rst_count", w_t'(o_cycle_count), w_t'(0));
        check("rst_timeout", w_t'(o_timeout), w_t'(0));
        rst = 1'b0;

        // LOAD_CTX of 135 words with random valid gaps
        base = ctx_addr_log.size(); d0 = done_cnt;
        send_cmd(2'd0, 16'd135, 6'd0);
        for (int i = 0; i < 135; i++) exp_ctx.push_back({$urandom, $urandom});
        @(negedge clk);
        for (int i = 0; i < 135; i++) begin
            i_ctx_valid = 1'b0;
            repeat ($urandom_range(0, 3)) @(negedge clk);
            i_ctx_valid = 1'b1; i_ctx_data = exp_ctx[i];
            n = 0;
            while (!o_ctx_ready && n < 100) begin @(negedge clk); n++; end
            @(negedge clk);
        end
        i_ctx_valid = 1'b0;
        wait_done("load_done", 20);
        repeat (3) @(negedge clk);
        check("load_nwrites", w_t'(ctx_addr_log.size() - base), w_t'(135));
        for (int i = 0; i < 135 && base + i < ctx_addr_log.size(); i++) begin
            check("load_addr", w_t'(ctx_addr_log[base+i]), w_t'(i));
            check("load_data", w_t'(ctx_data_log[base+i]), w_t'(exp_ctx[i]));
        end
        check("load_one_done", w_t'(done_cnt - d0), w_t'(1));
        check("ctx_strobes", w_t'(strobe_err), w_t'(0));

        // LOAD_CTX len=0 is a no-op with a single done
        base = ctx_addr_log.size(); d0 = done_cnt;
        send_cmd(2'd0, 16'd0, 6'd0);
        wait_done("load0_done", 10);
        repeat (3) @(negedge clk);
        check("load0_nwrites", w_t'(ctx_addr_log.size() - base), w_t'(0));
        check("load0_one_done", w_t'(done_cnt - d0), w_t'(1));

        // INIT_STATE for several qubit counts, including below one state word
        foreach (qtab[t]) begin
            nw = n_words(qtab[t]);
            base = wr_addr_log.size(); d0 = done_cnt;
            send_cmd(2'd1, 16'd0, 6'(qtab[t]));
            wait_done("init_done", 400);
            repeat (3) @(negedge clk);
            check("init_nwrites", w_t'(wr_addr_log.size() - base), w_t'(nw));
            for (int i = 0; i < nw && base + i < wr_addr_log.size(); i++) begin
                check("init_addr", w_t'(wr_addr_log[base+i]), w_t'(i));
                check("init_data", wr_data_log[base+i], (i == 0) ? one_vec : w_t'(0));
            end
            check("init_one_done", w_t'(done_cnt - d0), w_t'(1));
        end

        run_test(500, 1'b0);
`ifdef QEA_SEQ_TIMEOUT_EN
        d0 = done_cnt;
        send_cmd(2'd2, 16'd0, 6'd0);
        wait_start();
        @(negedge clk);
        wait_done("to_done", 2000);
        check("to_count", w_t'(o_cycle_count), w_t'(1000));
        check("to_flag", w_t'(o_timeout), w_t'(1));
        repeat (4) @(negedge clk);
        check("to_sticky", w_t'(o_timeout), w_t'(1));
        check("to_one_done", w_t'(done_cnt - d0), w_t'(1));
`else
        run_test(1200, 1'b0);
`endif

        // READOUT with random backpressure
        for (int t = 0; t < 2; t++) begin
            nw = (t == 0) ? n_words(9) : n_words(2);
            base = beat_log.size(); rbase = rd_addr_log.size(); d0 = done_cnt;
            send_cmd(2'd3, 16'd0, (t == 0) ? 6'd9 : 6'd2);
            n = 0; got = 0;
            while (got == 0 && n < 5000) begin
                @(posedge clk); #1 i_rd_ready = 1'($urandom_range(0, 1));
                @(negedge clk);
                if (o_done) got = 1;
                n++;
            end
            check("rd_done", w_t'(got), w_t'(1));
            i_rd_ready = 1'b0;
            repeat (3) @(negedge clk);
            check("rd_nbeats", w_t'(beat_log.size() - base), w_t'(nw));
            check("rd_nreads", w_t'(rd_addr_log.size() - rbase), w_t'(nw));
            for (int i = 0; i < nw && base + i < beat_log.size(); i++)
                check("rd_data", beat_log[base+i], pattern(16'(i)));
            for (int i = 0; i < nw && rbase + i < rd_addr_log.size(); i++)
                check("rd_addr", w_t'(rd_addr_log[rbase+i]), w_t'(i));
            check("rd_one_done", w_t'(done_cnt - d0), w_t'(1));
            check("rd_stall_stable", w_t'(stall_err), w_t'(0));
        end

        // Command valid held high: one accept per IDLE cycle
        d0 = done_cnt;
        @(posedge clk); #1;
        i_cmd_valid = 1'b1; i_cmd_op = 2'd0; i_cmd_len = 16'd0;
        repeat (10) @(posedge clk);
        #1 i_cmd_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("held_cmd_dones", w_t'(done_cnt - d0), w_t'(5));

        // Reset in the middle of INIT at word 40
        send_cmd(2'd1, 16'd0, 6'd9);
        n = 0;
        while (!(o_state_ena && o_state_addra == 16'd40) && n < 200) begin @(negedge clk); n++; end
        check("init_reached_40", w_t'(o_state_addra), w_t'(40));
        #2 rst = 1'b1;
        #1;
        check("abort_cmd_ready", w_t'(o_cmd_ready), w_t'(1));
        check("abort_busy", w_t'(o_busy), w_t'(0));
        check("abort_strobes", w_t'({o_state_ena, o_state_wea, o_ctx_en, o_start, o_done, o_rd_valid}), w_t'(0));
        check("abort_addr_data", w_t'({o_state_addra, o_state_dina[255:64]}), w_t'(0));
        @(negedge clk);
        rst = 1'b0;
        #1;
        base = wr_addr_log.size(); d0 = done_cnt;
        repeat (10) @(negedge clk);
        check("abort_no_done", w_t'(done_cnt - d0), w_t'(0));
        check("abort_no_writes", w_t'(wr_addr_log.size() - base), w_t'(0));
        check("abort_idle", w_t'(o_cmd_ready), w_t'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached checks=%0d errors=%0d", checks, errors);
        $fatal(1, "time limit");
    end
endmodule
